// File: rtl/tso_pkt_rx.sv
// TSO byte-stream receiver: checks sync/length framing and packs bytes into tagged 32-bit words.
// A show-ahead FIFO buffers the words; space for a whole packet is reserved when it starts.
`timescale 1ns/1ps
module tso_pkt_rx #(
   parameter int unsigned PKT_LEN    = 188,
   parameter logic [7:0]  SYNC_BYTE  = 8'h47,
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned LOCK_PKTS  = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_err,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [31:0] word_data,
   output logic        word_sop,
   output logic        word_eop,
   output logic        word_err,
   output logic        locked,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt,
   output logic [15:0] drop_cnt
);

   localparam int unsigned WORDS  = PKT_LEN / 4;
   localparam int unsigned BCNT_W = $clog2(PKT_LEN);
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned RUN_W  = $clog2(LOCK_PKTS + 1);

   typedef struct packed {
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic        err;
   } word_t;

   typedef enum logic [1:0] {HUNT, RECV, SKIP} state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [23:0]         asm_q, asm_d;
   logic                sticky_q, sticky_d;
   logic [RUN_W-1:0]    run_q;

   logic                start_byte, flush, space_ok;
   logic                wr_en, rd_en;
   word_t               wr_word;
   logic                good_pkt, run_clr, inc_drop;
   logic [1:0]          err_inc;
   logic [CNT_W-1:0]    free_words;

   word_t               mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                valid_q;

   assign start_byte = rx_valid & rx_start;
   assign flush      = (state_q == RECV) & start_byte;
   // A flush write in this cycle consumes space not yet visible in count_q.
   assign free_words = CNT_W'(FIFO_DEPTH) - count_q - CNT_W'(flush);
   assign space_ok   = free_words >= CNT_W'(WORDS);

   always_ff @(posedge clk) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      asm_d      = asm_q;
      sticky_d   = sticky_q;
      wr_en      = 1'b0;
      wr_word    = '0;
      good_pkt   = 1'b0;
      run_clr    = 1'b0;
      inc_drop   = 1'b0;
      err_inc    = 2'd0;

      case (state_q)
         RECV: begin
            if (start_byte) begin
               wr_en       = 1'b1;
               wr_word.sop = byte_cnt_q < BCNT_W'(4);
               wr_word.eop = 1'b1;
               wr_word.err = 1'b1;
               case (byte_cnt_q[1:0])
                  2'd1:    wr_word.data = {asm_q[7:0], 24'h0};
                  2'd2:    wr_word.data = {asm_q[15:0], 16'h0};
                  2'd3:    wr_word.data = {asm_q[23:0], 8'h0};
                  default: wr_word.data = 32'h0;
               endcase
               err_inc = 2'd1;
               run_clr = 1'b1;
            end else if (rx_valid) begin
               asm_d      = {asm_q[15:0], rx_data};
               byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               sticky_d   = sticky_q | rx_err;
               if (byte_cnt_q[1:0] == 2'd3) begin
                  wr_en        = 1'b1;
                  wr_word.data = {asm_q, rx_data};
                  wr_word.sop  = byte_cnt_q == BCNT_W'(3);
               end
               if (byte_cnt_q == BCNT_W'(PKT_LEN - 1)) begin
                  wr_word.eop = 1'b1;
                  wr_word.err = sticky_q | rx_err;
                  good_pkt    = ~(sticky_q | rx_err);
                  run_clr     = sticky_q | rx_err;
                  state_d     = HUNT;
               end
            end
         end
         SKIP: begin
            if (!start_byte && rx_valid) begin
               byte_cnt_d = byte_cnt_q + BCNT_W'(1);
               if (byte_cnt_q == BCNT_W'(PKT_LEN - 1)) state_d = HUNT;
            end
         end
         default: ;
      endcase

      // Start byte handling is shared by all states.
      if (start_byte) begin
         if (rx_data != SYNC_BYTE) begin
            err_inc = err_inc + 2'd1;
            run_clr = 1'b1;
            state_d = HUNT;
         end else if (space_ok) begin
            asm_d      = {16'h0, rx_data};
            byte_cnt_d = BCNT_W'(1);
            sticky_d   = rx_err;
            state_d    = RECV;
         end else begin
            inc_drop   = 1'b1;
            byte_cnt_d = BCNT_W'(1);
            state_d    = SKIP;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q <= '0;
         asm_q      <= '0;
         sticky_q   <= 1'b0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         asm_q      <= asm_d;
         sticky_q   <= sticky_d;
      end
   end

   // Lock run, lock flag and saturating statistics.
   logic [16:0] err_sum;
   assign err_sum = {1'b0, err_cnt} + 17'(err_inc);

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q    <= '0;
         locked   <= 1'b0;
         pkt_cnt  <= '0;
         err_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (run_clr) begin
            run_q <= '0;
            if (err_inc != 2'd0) locked <= 1'b0;
         end else if (good_pkt) begin
            if (run_q < RUN_W'(LOCK_PKTS)) run_q <= run_q + RUN_W'(1);
            if (run_q + RUN_W'(1) >= RUN_W'(LOCK_PKTS)) locked <= 1'b1;
         end
         if (good_pkt && pkt_cnt != 16'hFFFF)  pkt_cnt  <= pkt_cnt + 16'd1;
         if (inc_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end
   end

   // Show-ahead FIFO.
   assign rd_en = valid_q & word_ready;

   always_comb begin
      count_d = count_q;
      if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
      else if (!wr_en && rd_en) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         count_q <= count_d;
         valid_q <= count_d != '0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_word;
   end

   word_t head;
   assign head       = mem[rd_ptr];
   assign word_valid = valid_q;
   assign word_data  = valid_q ? head.data : 32'h0;
   assign word_sop   = valid_q & head.sop;
   assign word_eop   = valid_q & head.eop;
   assign word_err   = valid_q & head.err;

endmodule
